// File: rtl/calc_pkg.sv
// Shared calculator display constants: active-low {g,f,e,d,c,b,a} segment
// patterns and the digit count of the multiplexed display.
package calc_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low 7-segment pattern; non-BCD codes show a dash.
module bcd_to_seg
    import calc_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Latches a 4-digit BCD word and scans it onto a common-anode 7-segment display,
// swapping in new values only at frame boundaries so the display never tears.
module bcd_seg_scanner
    import calc_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd_in,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame
);

    localparam int         CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [1:0] LAST_SLOT = 2'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [15:0]      shadow;
    logic [15:0]      display;
    logic             pending;

    logic             slot_wrap;
    logic             boundary;

    logic [3:0]       digit_p0;
    logic [15:0]      upper_p0;
    logic             blank_p0;
    logic [6:0]       dec_seg_p0;
    logic [3:0]       an_p0;

    logic [3:0]       an_p1;
    logic [6:0]       seg_p1;
    logic             frame_p1;

    assign slot_wrap = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign boundary  = slot_wrap && (idx == LAST_SLOT);

    // Stage p0: select the active digit and decide whether it is a leading zero
    assign digit_p0 = display[{idx, 2'b00} +: 4];
    assign upper_p0 = display >> {idx, 2'b00};
    assign blank_p0 = BLANK_LZ && (idx != 2'd0) && (upper_p0 == 16'd0);
    assign an_p0    = blank_p0 ? 4'b1111 : ~(4'b0001 << idx);

    bcd_to_seg u_dec (
        .digit (digit_p0),
        .seg   (dec_seg_p0)
    );

    // Stage p1: registered pin drivers, one cycle behind the slot index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            idx      <= 2'd0;
            shadow   <= 16'd0;
            display  <= 16'd0;
            pending  <= 1'b0;
            an_p1    <= 4'b1111;
            seg_p1   <= SEG_OFF;
            frame_p1 <= 1'b0;
        end else begin
            cnt      <= slot_wrap ? '0 : cnt + CNT_W'(1);
            if (slot_wrap)
                idx <= idx + 2'd1;
            frame_p1 <= boundary;

            if (load)
                shadow <= bcd_in;

            // A load on the boundary cycle itself goes straight to the display
            if (boundary) begin
                pending <= 1'b0;
                if (load)
                    display <= bcd_in;
                else if (pending)
                    display <= shadow;
            end else if (load) begin
                pending <= 1'b1;
            end

            an_p1  <= an_p0;
            seg_p1 <= blank_p0 ? SEG_OFF : dec_seg_p0;
        end
    end

    assign an    = an_p1;
    assign seg   = seg_p1;
    assign frame = frame_p1;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Bench for bcd_seg_scanner: two instances (leading-zero blanking on/off) checked
// every cycle against a frame-level model, plus hand-computed slot expectations.
module tb_bcd_seg_scanner;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        load   = 1'b0;
    logic [15:0] bcd_in = 16'd0;

    logic [3:0] an_lz, an_all;
    logic [6:0] seg_lz, seg_all;
    logic       frame_lz, frame_all;

    bcd_seg_scanner #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) u_lz (
        .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .load(load),
        .an(an_lz), .seg(seg_lz), .frame(frame_lz));

    bcd_seg_scanner #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) u_all (
        .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .load(load),
        .an(an_all), .seg(seg_all), .frame(frame_all));

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [6:0] pat [16];
    initial begin
        pat[0] = 7'h40; pat[1] = 7'h79; pat[2] = 7'h24; pat[3] = 7'h30;
        pat[4] = 7'h19; pat[5] = 7'h12; pat[6] = 7'h02; pat[7] = 7'h78;
        pat[8] = 7'h00; pat[9] = 7'h10;
        for (int i = 10; i < 16; i++) pat[i] = 7'h3F;
    end

    // Model state: rising edges since reset release, shown value, most recent unshown load
    int          edges;
    logic [15:0] m_disp, m_next;
    bit          m_have_next;
    logic [3:0]  e_an_lz, e_an_all;
    logic [6:0]  e_seg_lz, e_seg_all;
    logic        e_frame;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void expect_slot(input int s, input bit blz, output logic [3:0] a,
                                        output logic [6:0] sg);
        int upper;
        upper = int'(m_disp) >> (4 * s);
        if (blz && s > 0 && upper == 0) begin
            a  = 4'hF;
            sg = 7'h7F;
        end else begin
            a  = 4'hF ^ 4'(1 << s);
            sg = pat[upper % 16];
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int s;
        if (!rst_n) begin
            edges       = 0;
            m_disp      = 16'd0;
            m_next      = 16'd0;
            m_have_next = 1'b0;
            e_an_lz     = 4'hF;
            e_an_all    = 4'hF;
            e_seg_lz    = 7'h7F;
            e_seg_all   = 7'h7F;
            e_frame     = 1'b0;
        end else begin
            edges++;
            s = ((edges - 1) / DIV) % 4;
            expect_slot(s, 1'b1, e_an_lz, e_seg_lz);
            expect_slot(s, 1'b0, e_an_all, e_seg_all);
            e_frame = (edges % FRAME) == 0;
            if (e_frame) begin
                if (load)             m_disp = bcd_in;
                else if (m_have_next) m_disp = m_next;
                m_have_next = 1'b0;
            end else if (load) begin
                m_next      = bcd_in;
                m_have_next = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("an_lz",     16'(an_lz),     16'(e_an_lz));
        check("seg_lz",    16'(seg_lz),    16'(e_seg_lz));
        check("frame_lz",  16'(frame_lz),  16'(e_frame));
        check("an_all",    16'(an_all),    16'(e_an_all));
        check("seg_all",   16'(seg_all),   16'(e_seg_all));
        check("frame_all", 16'(frame_all), 16'(e_frame));
    end

    task automatic wait_phase(input int ph);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((edges % FRAME) != ph && n < 64);
        if (n >= 64) check("phase_timeout", 16'(n), 16'(0));
    endtask

    task automatic do_load(input logic [15:0] v);
        bcd_in = v;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic check_slot(input int s, input logic [3:0] a_lz, input logic [6:0] s_lz,
                              input logic [3:0] a_all, input logic [6:0] s_all);
        wait_phase(1 + 4 * s);
        check("slot_an_lz",   16'(an_lz),   16'(a_lz));
        check("slot_seg_lz",  16'(seg_lz),  16'(s_lz));
        check("slot_an_all",  16'(an_all),  16'(a_all));
        check("slot_seg_all", 16'(seg_all), 16'(s_all));
    endtask

    task automatic check_reset_outputs();
        check("rst_an",    16'(an_lz),    16'h000F);
        check("rst_seg",   16'(seg_lz),   16'h007F);
        check("rst_frame", 16'(frame_lz), 16'h0000);
        check("rst_an_all", 16'(an_all),  16'h000F);
    endtask

    task automatic frame_gap(output int gap);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (frame_lz !== 1'b1 && gap < 64);
    endtask

    initial begin
        int gap;
        // 1: reset state, first slot, frame period
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        check("first_an",  16'(an_lz),  16'h000E);
        check("first_seg", 16'(seg_lz), 16'h0040);
        frame_gap(gap);
        check("first_frame_gap", 16'(gap), 16'd15);
        frame_gap(gap);
        check("frame_period", 16'(gap), 16'd16);

        // 2: 0255 with leading-zero blanking
        do_load(16'h0255);
        check_slot(0, 4'b1110, 7'b0010010, 4'b1110, 7'b0010010);
        check_slot(1, 4'b1101, 7'b0010010, 4'b1101, 7'b0010010);
        check_slot(2, 4'b1011, 7'b0100100, 4'b1011, 7'b0100100);
        check_slot(3, 4'b1111, 7'b1111111, 4'b0111, 7'b1000000);

        // 3: all zeros keeps digit 0 lit
        do_load(16'h0000);
        check_slot(0, 4'b1110, 7'b1000000, 4'b1110, 7'b1000000);
        check_slot(1, 4'b1111, 7'b1111111, 4'b1101, 7'b1000000);
        check_slot(2, 4'b1111, 7'b1111111, 4'b1011, 7'b1000000);
        check_slot(3, 4'b1111, 7'b1111111, 4'b0111, 7'b1000000);

        // 4: two loads in one frame, last wins; A shows a dash
        do_load(16'h4095);
        do_load(16'h00A1);
        check_slot(0, 4'b1110, 7'b1111001, 4'b1110, 7'b1111001);
        check_slot(1, 4'b1101, 7'b0111111, 4'b1101, 7'b0111111);
        check_slot(2, 4'b1111, 7'b1111111, 4'b1011, 7'b1000000);
        check_slot(3, 4'b1111, 7'b1111111, 4'b0111, 7'b1000000);

        // 5: load on the boundary cycle bypasses the shadow
        wait_phase(FRAME - 1);
        do_load(16'h1234);
        check("bypass_pending", 16'(u_lz.pending), 16'h0000);
        check_slot(0, 4'b1110, 7'b0011001, 4'b1110, 7'b0011001);
        check_slot(1, 4'b1101, 7'b0110000, 4'b1101, 7'b0110000);
        check_slot(2, 4'b1011, 7'b0100100, 4'b1011, 7'b0100100);
        check_slot(3, 4'b0111, 7'b1111001, 4'b0111, 7'b1111001);

        // 6: reset mid-slot 2 with a load pending
        wait_phase(8);
        do_load(16'h0789);
        check("mid_pending", 16'(u_lz.pending), 16'h0001);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        check_slot(0, 4'b1110, 7'b1000000, 4'b1110, 7'b1000000);
        check_slot(1, 4'b1111, 7'b1111111, 4'b1101, 7'b1000000);
        check_slot(0, 4'b1110, 7'b1000000, 4'b1110, 7'b1000000);
        check_slot(2, 4'b1111, 7'b1111111, 4'b1011, 7'b1000000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
